// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter sequencing accesses onto a
// single-port synchronous memory with registered read data.
module mem_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic                     we0,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0]    wdata0,
  input  logic                     req1,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    wdata1,
  output logic                     ack0,
  output logic                     ack1,
  output logic [DATA_WIDTH-1:0]    rdata0,
  output logic [DATA_WIDTH-1:0]    rdata1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic                     busy,
  output logic                     mem_cs,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_d,
  input  logic [DATA_WIDTH-1:0]    mem_q
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD
  } state_t;

  state_t state, state_nx;
  logic   last;
  logic   win;
  logic   any_req;
  logic   grant1;

  assign any_req = req0 | req1;
  // On a tie the port that was not served last wins
  assign grant1  = req1 & (~req0 | ~last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (any_req) state_nx = ISSUE;
      ISSUE:   state_nx = mem_we ? IDLE : WAIT_RD;
      WAIT_RD: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last     <= 1'b1;
      win      <= 1'b0;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_d    <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            mem_cs   <= 1'b1;
            mem_we   <= grant1 ? we1 : we0;
            mem_addr <= grant1 ? addr1 : addr0;
            mem_d    <= grant1 ? wdata1 : wdata0;
            win      <= grant1;
            last     <= grant1;
          end
        end
        ISSUE: begin
          mem_cs <= 1'b0;
          mem_we <= 1'b0;
        end
        WAIT_RD: begin
          if (win) begin
            rdata1  <= mem_q;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= mem_q;
            rvalid0 <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ack0 = (state == ISSUE) & ~win;
  assign ack1 = (state == ISSUE) & win;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural
// single-port memory behind it.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, ack1, rvalid0, rvalid1, busy;
  logic [15:0] rdata0, rdata1;
  logic        mem_cs, mem_we;
  logic [15:0] mem_addr, mem_d, mem_q;

  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(16), .ADDRESS_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .busy(busy),
    .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q)
  );

  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_d;
      else        mem_q <= mem[mem_addr[7:0]];
    end
  end

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [15:0] a0, d0;
    logic        r1, w1;
    logic [15:0] a1, d1;
    logic [6:0]  flg;
    logic [15:0] ma, md, rd0, rd1;
  } vec_t;

  function automatic vec_t mk(
    input logic rs,
    input logic r0, input logic w0,
    input logic [15:0] a0, input logic [15:0] d0,
    input logic r1, input logic w1,
    input logic [15:0] a1, input logic [15:0] d1,
    input logic [6:0] flg,
    input logic [15:0] ma, input logic [15:0] md,
    input logic [15:0] rd0, input logic [15:0] rd1);
    vec_t v;
    v.rst = rs;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.flg = flg;
    v.ma = ma; v.md = md; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [70:0] outs();
    return {ack0, ack1, rvalid0, rvalid1, busy, mem_cs, mem_we,
            mem_addr, mem_d, rdata0, rdata1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
  endtask

  vec_t vt [13];
  int   grants [$];
  int   n, rc, cyc, lastc;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem_q = '0;
    // flags: ack0 ack1 rv0 rv1 busy cs we
    vt[0]  = mk(0, 1,1,3,15, 0,0,0,0, 7'b1000111, 3,15, 0,0);
    vt[1]  = mk(0, 0,0,0,0,  0,0,0,0, 7'b0000000, 3,15, 0,0);
    vt[2]  = mk(0, 0,0,0,0,  1,0,3,0, 7'b0100110, 3,0,  0,0);
    vt[3]  = mk(0, 0,0,0,0,  0,0,0,0, 7'b0000100, 3,0,  0,0);
    vt[4]  = mk(0, 0,0,0,0,  0,0,0,0, 7'b0001000, 3,0,  0,15);
    vt[5]  = mk(0, 0,0,0,0,  0,0,0,0, 7'b0000000, 3,0,  0,15);
    vt[6]  = mk(1, 0,0,0,0,  0,0,0,0, 7'b0000000, 0,0,  0,0);
    vt[7]  = mk(0, 1,1,5,16, 1,0,5,0, 7'b1000111, 5,16, 0,0);
    vt[8]  = mk(0, 0,0,0,0,  1,0,5,0, 7'b0000000, 5,16, 0,0);
    vt[9]  = mk(0, 0,0,0,0,  1,0,5,0, 7'b0100110, 5,0,  0,0);
    vt[10] = mk(0, 0,0,0,0,  0,0,0,0, 7'b0000100, 5,0,  0,0);
    vt[11] = mk(0, 0,0,0,0,  0,0,0,0, 7'b0001000, 5,0,  0,16);
    vt[12] = mk(0, 0,0,0,0,  0,0,0,0, 7'b0000000, 5,0,  0,16);

    rst = 1;
    idle_in();
    tick();
    chk("reset", {57'd0, outs()}, 128'd0);

    for (int i = 0; i < 13; i++) begin
      rst = vt[i].rst;
      req0 = vt[i].r0; we0 = vt[i].w0;
      addr0 = vt[i].a0; wdata0 = vt[i].d0;
      req1 = vt[i].r1; we1 = vt[i].w1;
      addr1 = vt[i].a1; wdata1 = vt[i].d1;
      tick();
      chk($sformatf("vec%0d", i), {57'd0, outs()},
          {57'd0, vt[i].flg, vt[i].ma, vt[i].md,
           vt[i].rd0, vt[i].rd1});
    end
    rst = 0;
    idle_in();

    // fairness: both ports stream writes
    req0 = 1; we0 = 1; addr0 = 20; wdata0 = 7;
    req1 = 1; we1 = 1; addr1 = 21; wdata1 = 9;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (ack0 | ack1) grants.push_back(ack1 ? 1 : 0);
      chk($sformatf("fair_busy%0d", c), {127'd0, busy},
          {127'd0, ack0 | ack1});
    end
    idle_in();
    chk("fair_count", grants.size(), 8);
    for (int i = 0; i < grants.size() && i < 8; i++)
      chk($sformatf("fair_order%0d", i), grants[i], i % 2);
    tick();

    // reset during WAIT_RD
    req0 = 1; we0 = 0; addr0 = 5;
    tick();
    chk("mr_ack0", {126'd0, ack0, ack1}, 128'd2);
    req0 = 0;
    tick();
    chk("mr_wait", {126'd0, busy, mem_cs}, 128'd2);
    rst = 1;
    #1;
    chk("mr_async", {57'd0, outs()}, 128'd0);
    tick();
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("mr_norv%0d", c),
          {126'd0, rvalid0, rvalid1}, 128'd0);
    end
    req0 = 1; we0 = 1; addr0 = 7; wdata0 = 1;
    req1 = 1; we1 = 1; addr1 = 8; wdata1 = 2;
    tick();
    chk("mr_tie", {126'd0, ack0, ack1}, 128'd2);
    idle_in();
    repeat (3) tick();

    // single-port write stream
    req0 = 1; we0 = 1; addr0 = 0; wdata0 = 100;
    n = 0; cyc = 0; lastc = 0;
    while (n < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (ack1) chk("ws_ack1", 1, 0);
      if (ack0) begin
        if (n > 0)
          chk($sformatf("ws_gap%0d", n), cyc - lastc, 2);
        lastc = cyc;
        n++;
        addr0 = 16'(n);
        wdata0 = 16'(100 + n);
        if (n == 4) req0 = 0;
      end
    end
    if (n != 4) chk("ws_timeout", n, 4);
    idle_in();
    repeat (2) tick();

    // single-port read stream
    req0 = 1; we0 = 0; addr0 = 0;
    n = 0; rc = 0; cyc = 0; lastc = 0;
    while ((n < 4 || rc < 4) && cyc < 60) begin
      tick();
      cyc++;
      if (ack1 | rvalid1) chk("rs_port1", 1, 0);
      if (rvalid0) begin
        chk($sformatf("rs_data%0d", rc), rdata0, 100 + rc);
        rc++;
      end
      if (ack0) begin
        if (n > 0)
          chk($sformatf("rs_gap%0d", n), cyc - lastc, 3);
        lastc = cyc;
        n++;
        addr0 = 16'(n);
        if (n == 4) req0 = 0;
      end
    end
    if (n != 4 || rc != 4) chk("rs_timeout", n + rc, 8);
    idle_in();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter and sequencer for the single-port synchronous memory (cs/we/addr/d/q interface, one-cycle registered read data). It accepts independent read/write requests from two requesters and serializes them onto the memory, one access at a time. It returns acknowledges and read data to the originating port. It sits between the memory instance and its two clients.

## Interface
- DATA_WIDTH, 16, width of data paths
- ADDRESS_WIDTH, 16, width of address paths
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request from port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read; qualified by reqN
- addr0 / addr1  in  ADDRESS_WIDTH  access address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- ack0 / ack1  out  1  one-cycle pulse; access accepted and issued to memory
- rdata0 / rdata1  out  DATA_WIDTH  read data; held until that port's next read completes
- rvalid0 / rvalid1  out  1  one-cycle pulse; rdataN valid
- busy  out  1  high whenever state != IDLE
- mem_cs  out  1  memory chip select (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  ADDRESS_WIDTH  memory address (registered)
- mem_d  out  DATA_WIDTH  memory write data (registered)
- mem_q  in  DATA_WIDTH  memory read data; valid the cycle after a read is issued

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If no request, stay in IDLE.
  - Otherwise select a winner and go to ISSUE.
  - At the same edge, load mem_cs=1, mem_we=weN, mem_addr=addrN, mem_d=wdataN from the winner, and record the winner id.
- Arbitration: single priority pointer `last` (id of the last port served).
  - Tie: grant the port != last.
  - Single requester: always granted.
  - `last` updates to the winner at the grant edge.
- ISSUE: mem_cs high for exactly this cycle; ackN high for the winner.
  - Write: next state IDLE; mem_cs/mem_we cleared.
  - Read: next state WAIT_RD; mem_cs cleared.
- WAIT_RD: mem_q is valid. At the end of the cycle, register rdataN <= mem_q, assert rvalidN for the next cycle, go to IDLE.
- Requester protocol: hold reqN/weN/addrN/wdataN stable until ackN is seen; deassert reqN on the edge that samples ackN=1 unless issuing a new request.
- Request fields are latched at the grant edge. Dropping reqN after the grant does not cancel the access.
- Only one access is in flight at a time. A request arriving during ISSUE or WAIT_RD waits for IDLE.
- mem_addr and mem_d hold their last values when mem_cs=0. mem_we is 0 whenever mem_cs=0.
- The other port's rdata never changes on a read completion.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, last=1 (port 0 wins the first tie).
  - mem_cs, mem_we, mem_addr, mem_d = 0.
  - ack0/1, rvalid0/1, busy = 0; rdata0/1 = 0.
- Request sampled at edge k in IDLE:
  - ackN and mem_cs are high during cycle k..k+1.
  - Memory performs the access at edge k+1.
- Write: 2 cycles per access (IDLE + ISSUE). The next grant is possible at edge k+2.
- Read: rvalidN and rdataN are valid during cycle k+2..k+3. 3 cycles per access; the next grant is possible at edge k+3.
- rvalidN coincides with IDLE. A new grant may occur at that same edge.
- Reset mid-access: the access is abandoned, with no ack or rvalid afterwards. If mem_cs was high, it drops immediately; the memory may or may not have completed the access.
- Both ports requesting continuously: grants alternate strictly 0,1,0,1,… No port waits more than one other access.

## Test plan
- Write: after reset, req0 with we0=1, addr0=3, wdata0=15 → one ISSUE cycle with mem_cs=1, mem_we=1, mem_addr=3, mem_d=15. ack0 pulses once; ack1, rvalid0 and rvalid1 stay 0.
- Read-back: req1 with we1=0, addr1=3 → mem_cs=1, mem_we=0 in ISSUE; ack1 pulses. Two cycles after the grant edge, rvalid1=1 and rdata1=15. rdata0 is unchanged.
- Tie after reset: req0 (write addr 5, data 16) and req1 (read addr 5) asserted in the same cycle → port 0 is granted first. Port 1 is granted next and returns rdata1=16.
- Fairness: both ports request back-to-back writes for 8 accesses → grant order 0,1,0,1,0,1,0,1. busy stays high except the single IDLE cycle between accesses.
- Reset mid-read: assert rst during WAIT_RD → all outputs go to 0 immediately and rvalidN never pulses. After release, port 0 wins the next tie.
- Single-port streaming: req0 held with successive addresses 0..3 while port 1 is idle → four consecutive grants to port 0, each 2 cycles apart for writes and 3 cycles apart for reads.
